// File: rtl/deca_qsys_nios2_gen2_cpu_mul_combine.sv
// deca_qsys_nios2_gen2_cpu_mul_combine: two-stage recombination of 16x16 partial products into a 32-bit low product
module deca_qsys_nios2_gen2_cpu_mul_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  logic             s1_valid;
  logic [31:0]      s1_p1;
  logic [15:0]      s1_cross;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_free, advance, accept;
  // handshake: flush blocks acceptance and suppresses the S1->S2 move
  always_comb begin
    s2_free  = ~out_valid | out_ready;
    advance  = s1_valid & s2_free & ~flush;
    in_ready = ~flush & (~s1_valid | s2_free);
    accept   = in_valid & in_ready;
    busy     = s1_valid | out_valid;
  end
  // valid bits: flush kills both stages, otherwise load/drain per handshake
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= flush ? 1'b0 : accept ? 1'b1 : advance ? 1'b0 : s1_valid;
      out_valid <= flush ? 1'b0 : advance ? 1'b1 : out_ready ? 1'b0 : out_valid;
    end
  // stage 1 data: keep p1 whole, fold only the low halves of the cross terms
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_p1    <= '0;
      s1_cross <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_p1    <= M_mul_cell_p1;
      s1_cross <= M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
      s1_tag   <= in_tag;
    end
  // stage 2 data: add the shifted cross sum, dropping the carry out of bit 31
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      out_result <= s1_p1 + {s1_cross, 16'h0000};
      out_tag    <= s1_tag;
    end
endmodule

// File: tb/tb_deca_qsys_nios2_gen2_cpu_mul_combine.sv
// tb_deca_qsys_nios2_gen2_cpu_mul_combine: directed bench with queue-based reference model
module tb_deca_qsys_nios2_gen2_cpu_mul_combine;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [31:0] src1 = 0, src2 = 0, p1, p2, p3, out_result, held;
  logic [4:0] tag = 0, out_tag;
  int checks = 0, failures = 0, n_out = 0, cyc = 0, c0;
  bit quiet = 0, acc;
  typedef struct {logic [31:0] r; logic [4:0] t; int age;} ent_t;
  ent_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign p1 = {16'h0, src1[15:0]} * {16'h0, src2[15:0]};
  assign p2 = {16'h0, src1[15:0]} * {16'h0, src2[31:16]};
  assign p3 = {16'h0, src1[31:16]} * {16'h0, src2[15:0]};

  deca_qsys_nios2_gen2_cpu_mul_combine #(.TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3), .in_tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ov();
    return q.size() >= 2 || (q.size() == 1 && q[0].age >= 1);
  endfunction

  function automatic bit m_ir();
    return !flush && !(q.size() >= 2 && !out_ready);
  endfunction

  // reference model: in-order queue of full products; an entry is visible one edge after acceptance
  always @(posedge clk or negedge reset_n)
    if (!reset_n) q.delete();
    else begin
      bit pop, a;
      pop = m_ov() && out_ready;
      a = in_valid && m_ir();
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (a) q.push_back('{src1 * src2, tag, 0});
      end
    end

  // per-cycle comparison against the model
  always @(negedge clk)
    if (reset_n && !quiet) begin
      chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov()});
      chk("in_ready", {31'h0, in_ready}, {31'h0, m_ir()});
      chk("busy", {31'h0, busy}, {31'h0, q.size() > 0});
      if (m_ov()) begin
        chk("out_result", out_result, q[0].r);
        chk("out_tag", {27'h0, out_tag}, {27'h0, q[0].t});
        if (out_ready) n_out++;
      end
    end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    src1 = a; src2 = b; tag = t; in_valid = 1; acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    idle(2);
    reset_n = 1;
    idle(1);

    // basic with literal latency and value
    push(32'h00030002, 32'h00050004, 5'd3);
    @(negedge clk) chk("lat_not_yet", {31'h0, out_valid}, 0);
    @(negedge clk) chk("lat_valid", {31'h0, out_valid}, 1);
    chk("basic_result", out_result, 32'h00160008);
    chk("basic_tag", {27'h0, out_tag}, 3);
    idle(1);

    // wrap-around
    push(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
    @(negedge clk); @(negedge clk);
    chk("wrap_result", out_result, 32'h00000001);
    idle(2);

    // backpressure
    out_ready = 0;
    push(32'h00001234, 32'h00010002, 5'd1);
    push(32'h12345678, 32'h9ABCDEF0, 5'd2);
    src1 = 32'hDEADBEEF; src2 = 32'h0BADF00D; tag = 5'd3; in_valid = 1;
    @(negedge clk);
    chk("bp_in_ready", {31'h0, in_ready}, 0);
    held = out_result;
    chk("bp_head", out_result, 32'h00001234 * 32'h00010002);
    idle(3);
    @(negedge clk) chk("bp_stable", out_result, held);
    @(posedge clk); #1;
    out_ready = 1;
    push(32'hDEADBEEF, 32'h0BADF00D, 5'd3);
    idle(4);

    // streaming
    c0 = n_out;
    begin
      int s;
      s = cyc;
      for (int i = 0; i < 16; i++) push($urandom, $urandom, 5'($urandom_range(0, 31)));
      chk("stream_cycles", cyc - s, 16);
    end
    idle(2);
    chk("stream_count", n_out - c0, 16);

    // flush with full pipe
    out_ready = 0;
    push(32'h11111111, 32'h22222222, 5'd9);
    push(32'h33333333, 32'h44444444, 5'd10);
    flush = 1; in_valid = 1; src1 = 32'h5; src2 = 32'h6; tag = 5'd11;
    @(negedge clk) chk("flush_in_ready", {31'h0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", {31'h0, out_valid}, 0);
    chk("flush_busy", {31'h0, busy}, 0);
    chk("flush_in_ready1", {31'h0, in_ready}, 1);
    idle(3);

    // async reset with both stages valid
    out_ready = 0;
    push(32'h00ABCDEF, 32'h00001111, 5'd12);
    push(32'h01020304, 32'h05060708, 5'd13);
    @(negedge clk) chk("pre_rst_busy", {31'h0, busy}, 1);
    #2 quiet = 1; reset_n = 0; out_ready = 1;
    #1 chk("arst_out_valid", {31'h0, out_valid}, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_busy", {31'h0, busy}, 0);
    idle(2);
    reset_n = 1; quiet = 0;
    idle(5);
    push(32'h00000010, 32'h00000010, 5'd4);
    @(negedge clk); @(negedge clk);
    chk("post_rst_result", out_result, 32'h00000100);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
